// File: rtl/md_iter_unit_if.sv
// Handshake and operand bus between the EX stage and the iterative
// multiply/divide unit. EX is the master; the unit is the slave.
interface md_iter_unit_if #(
    parameter int WIDTH = 32
);
    logic                 start_i;
    logic [1:0]           op_i;
    logic [WIDTH-1:0]     src1_i;
    logic [WIDTH-1:0]     src2_i;
    logic                 cancel_i;
    logic                 busy_o;
    logic                 done_o;
    logic [2*WIDTH-1:0]   result_o;
    logic                 div_by_zero_o;

    modport master (
        output start_i, op_i, src1_i, src2_i, cancel_i,
        input  busy_o, done_o, result_o, div_by_zero_o
    );

    modport slave (
        input  start_i, op_i, src1_i, src2_i, cancel_i,
        output busy_o, done_o, result_o, div_by_zero_o
    );
endinterface

// File: rtl/md_iter_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit. One bit per cycle: a shift-add
// multiplier and a restoring divider sharing a single 2*WIDTH accumulator.
// Operands are reduced to magnitudes at start; signs are reapplied in FIX.
module md_iter_unit #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           resetn,
    md_iter_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;      // mult: {partial hi, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]   opnd;     // multiplicand magnitude or divisor magnitude
    logic               is_div;
    logic               neg_a;
    logic               neg_b;
    logic               busy_q;
    logic               done_q;
    logic [2*WIDTH-1:0] result_q;
    logic               dbz_q;

    // Operand magnitudes at start (signed ops take |x|; most-negative maps to 2^(W-1))
    logic               signed_op;
    logic               src1_neg;
    logic               src2_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               div_zero;

    // Iteration datapath
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_sh;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_next;

    // Sign fix-up
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [2*WIDTH-1:0] prod_fix;
    logic [2*WIDTH-1:0] fix_result;

    // Start-time decode: signedness, magnitudes and the divide-by-zero shortcut
    always_comb begin
        signed_op = ~bus.op_i[0];
        src1_neg  = signed_op & bus.src1_i[WIDTH-1];
        src2_neg  = signed_op & bus.src2_i[WIDTH-1];
        a_mag     = src1_neg ? (~bus.src1_i + 1'b1) : bus.src1_i;
        b_mag     = src2_neg ? (~bus.src2_i + 1'b1) : bus.src2_i;
        div_zero  = bus.op_i[1] & (bus.src2_i == '0);
    end

    // One multiply step (add-then-shift) and one restoring divide step
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};
        // Shifted remainder needs WIDTH+1 bits; when it is >= divisor the
        // difference always fits back into WIDTH bits.
        rem_sh   = acc[2*WIDTH-1:WIDTH-1];
        div_ge   = rem_sh >= {1'b0, opnd};
        div_rem  = rem_sh[WIDTH-1:0] - opnd;
        div_next = div_ge ? {div_rem, acc[WIDTH-2:0], 1'b1}
                          : {acc[2*WIDTH-2:0], 1'b0};
    end

    // Reapply signs: product by sign xor, quotient by sign xor, remainder by dividend sign
    always_comb begin
        quot       = acc[WIDTH-1:0];
        rem        = acc[2*WIDTH-1:WIDTH];
        quot_fix   = (neg_a ^ neg_b) ? (~quot + 1'b1) : quot;
        rem_fix    = neg_a ? (~rem + 1'b1) : rem;
        prod_fix   = (neg_a ^ neg_b) ? (~acc + 1'b1) : acc;
        fix_result = is_div ? {rem_fix, quot_fix} : prod_fix;
    end

    // Control FSM, accumulator iteration and registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        if (div_zero) begin
                            // Fast path: no iteration, result in the next cycle
                            result_q <= {bus.src1_i, {WIDTH{1'b1}}};
                            dbz_q    <= 1'b1;
                            done_q   <= 1'b1;
                        end else begin
                            is_div <= bus.op_i[1];
                            neg_a  <= src1_neg;
                            neg_b  <= src2_neg;
                            opnd   <= bus.op_i[1] ? b_mag : a_mag;
                            acc    <= {{WIDTH{1'b0}}, (bus.op_i[1] ? a_mag : b_mag)};
                            cnt    <= CNT_LOAD;
                            state  <= S_CALC;
                            busy_q <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    if (bus.cancel_i) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                        cnt    <= '0;
                    end else begin
                        acc <= is_div ? div_next : mul_next;
                        cnt <= cnt - CNT_ONE;
                        if (cnt == CNT_ONE) begin
                            state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    if (!bus.cancel_i) begin
                        result_q <= fix_result;
                        dbz_q    <= 1'b0;
                        done_q   <= 1'b1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy_o        = busy_q;
    assign bus.done_o        = done_q;
    assign bus.result_o      = result_q;
    assign bus.div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_md_iter_unit.sv
// Directed bench for md_iter_unit: a WIDTH=32 vector table plus hand-written
// cancel, reset, busy-start and WIDTH=8 sequences.
module tb_md_iter_unit;
    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    md_iter_unit_if #(.WIDTH(32)) bus32();
    md_iter_unit_if #(.WIDTH(8))  bus8();

    md_iter_unit #(.WIDTH(32)) u32 (.clk(clk), .resetn(resetn), .bus(bus32));
    md_iter_unit #(.WIDTH(8))  u8  (.clk(clk), .resetn(resetn), .bus(bus8));

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        logic        dbz;
        int          lat;
    } vec_t;

    localparam int NV = 13;
    vec_t tbl [NV];

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start an op in the current cycle, wait for done, check latency/busy/result
    task automatic run32(input string nm, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input logic dbz,
                         input int lat);
        int   cyc;
        logic bsy_bad;
        bus32.op_i    = op;
        bus32.src1_i  = a;
        bus32.src2_i  = b;
        bus32.start_i = 1'b1;
        tick();
        bus32.start_i = 1'b0;
        bus32.op_i    = ~op;
        bus32.src1_i  = ~a;
        bus32.src2_i  = ~b;
        cyc     = 1;
        bsy_bad = 1'b0;
        while (!bus32.done_o && cyc < 100) begin
            if (!bus32.busy_o) bsy_bad = 1'b1;
            tick();
            cyc++;
        end
        chk({nm, " latency"}, 64'(cyc), 64'(lat));
        chk({nm, " busy"}, {63'b0, bsy_bad | bus32.busy_o}, 64'd0);
        chk({nm, " result"}, bus32.result_o, exp);
        chk({nm, " dbz"}, {63'b0, bus32.div_by_zero_o}, {63'b0, dbz});
    endtask

    // Same for WIDTH=8; optionally fires a second start while busy
    task automatic run8(input string nm, input logic [1:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] exp, input logic dbz,
                        input int lat, input logic inj);
        int   cyc;
        logic bsy_bad;
        bus8.op_i    = op;
        bus8.src1_i  = a;
        bus8.src2_i  = b;
        bus8.start_i = 1'b1;
        tick();
        bus8.start_i = 1'b0;
        bus8.op_i    = ~op;
        bus8.src1_i  = ~a;
        bus8.src2_i  = ~b;
        cyc     = 1;
        bsy_bad = 1'b0;
        while (!bus8.done_o && cyc < 100) begin
            if (!bus8.busy_o) bsy_bad = 1'b1;
            if (inj && cyc == 3) begin
                bus8.op_i    = 2'b11;
                bus8.src1_i  = 8'h01;
                bus8.src2_i  = 8'h01;
                bus8.start_i = 1'b1;
            end else begin
                bus8.start_i = 1'b0;
            end
            tick();
            cyc++;
        end
        bus8.start_i = 1'b0;
        chk({nm, " latency"}, 64'(cyc), 64'(lat));
        chk({nm, " busy"}, {63'b0, bsy_bad | bus8.busy_o}, 64'd0);
        chk({nm, " result"}, {48'b0, bus8.result_o}, {48'b0, exp});
        chk({nm, " dbz"}, {63'b0, bus8.div_by_zero_o}, {63'b0, dbz});
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic seen_done;
        tbl[0]  = '{2'b00, 32'hFFFFFFFD, 32'd5,        64'hFFFFFFFF_FFFFFFF1, 1'b0, 34};
        tbl[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0, 34};
        tbl[2]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 1'b0, 34};
        tbl[3]  = '{2'b00, 32'd7,        32'hFFFFFFFE, 64'hFFFFFFFF_FFFFFFF2, 1'b0, 34};
        tbl[4]  = '{2'b01, 32'h00010000, 32'h00010000, 64'h00000001_00000000, 1'b0, 34};
        tbl[5]  = '{2'b10, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 1'b0, 34};
        tbl[6]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0, 34};
        tbl[7]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, 34};
        tbl[8]  = '{2'b11, 32'd7,        32'd2,        64'h00000001_00000003, 1'b0, 34};
        tbl[9]  = '{2'b11, 32'hFFFFFFFF, 32'd16,       64'h0000000F_0FFFFFFF, 1'b0, 34};
        tbl[10] = '{2'b10, 32'd0,        32'd5,        64'h00000000_00000000, 1'b0, 34};
        tbl[11] = '{2'b11, 32'h12345678, 32'd0,        64'h12345678_FFFFFFFF, 1'b1, 1};
        tbl[12] = '{2'b10, 32'd6,        32'd3,        64'h00000000_00000002, 1'b0, 34};

        resetn         = 1'b0;
        bus32.start_i  = 1'b0;
        bus32.op_i     = 2'b00;
        bus32.src1_i   = '0;
        bus32.src2_i   = '0;
        bus32.cancel_i = 1'b0;
        bus8.start_i   = 1'b0;
        bus8.op_i      = 2'b00;
        bus8.src1_i    = '0;
        bus8.src2_i    = '0;
        bus8.cancel_i  = 1'b0;
        #12;
        chk("reset busy",   {63'b0, bus32.busy_o}, 64'd0);
        chk("reset done",   {63'b0, bus32.done_o}, 64'd0);
        chk("reset result", bus32.result_o, 64'd0);
        chk("reset dbz",    {63'b0, bus32.div_by_zero_o}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        tick();

        // Table: each op starts in the done cycle of the previous one
        for (int i = 0; i < NV; i++)
            run32($sformatf("v%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                  tbl[i].exp, tbl[i].dbz, tbl[i].lat);

        // Cancel in cycle T+10 of a MULT
        bus32.op_i    = 2'b00;
        bus32.src1_i  = 32'd3;
        bus32.src2_i  = 32'd4;
        bus32.start_i = 1'b1;
        tick();
        bus32.start_i = 1'b0;
        seen_done = 1'b0;
        for (int c = 1; c < 10; c++) begin
            seen_done |= bus32.done_o;
            tick();
        end
        seen_done |= bus32.done_o;
        bus32.cancel_i = 1'b1;
        tick();
        bus32.cancel_i = 1'b0;
        chk("cancel busy",   {63'b0, bus32.busy_o}, 64'd0);
        chk("cancel done",   {63'b0, seen_done | bus32.done_o}, 64'd0);
        chk("cancel result", bus32.result_o, tbl[NV-1].exp);
        chk("cancel dbz",    {63'b0, bus32.div_by_zero_o}, {63'b0, tbl[NV-1].dbz});
        run32("after_cancel", 2'b00, 32'd3, 32'd4, 64'd12, 1'b0, 34);

        // Asynchronous reset at T+5 mid-operation
        bus32.op_i    = 2'b01;
        bus32.src1_i  = 32'd5;
        bus32.src2_i  = 32'd5;
        bus32.start_i = 1'b1;
        tick();
        bus32.start_i = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        #1 resetn = 1'b0;
        #1;
        chk("areset busy",   {63'b0, bus32.busy_o}, 64'd0);
        chk("areset done",   {63'b0, bus32.done_o}, 64'd0);
        chk("areset result", bus32.result_o, 64'd0);
        chk("areset dbz",    {63'b0, bus32.div_by_zero_o}, 64'd0);
        resetn = 1'b1;
        seen_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            seen_done |= bus32.done_o | bus32.busy_o;
        end
        chk("areset discarded", {63'b0, seen_done}, 64'd0);

        // WIDTH=8: start-while-busy ignored, then back-to-back ops
        run8("w8_mult_busy_start", 2'b00, 8'h80, 8'h80, 16'h4000, 1'b0, 10, 1'b1);
        run8("w8_div_overflow",    2'b10, 8'h80, 8'hFF, 16'h0080, 1'b0, 10, 1'b0);
        run8("w8_multu",           2'b01, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 10, 1'b0);
        run8("w8_div_zero",        2'b10, 8'h0F, 8'h00, 16'h0FFF, 1'b1, 1,  1'b0);
        run8("w8_divu",            2'b11, 8'hC8, 8'h07, 16'h041C, 1'b0, 10, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
